// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared defaults and helpers for the multi-channel PWM block.
//               - default PERIOD / DUTY_W / DEB_TICKS
//               - ch_sel_w : channel-select width, max(1, clog2(NUM_CH))
//               - sat_add / sat_sub : saturating duty arithmetic, done wider
//                 than any legal duty value so an increment cannot wrap
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

  localparam int DEF_PERIOD    = 10;
  localparam int DEF_DUTY_W    = 4;
  localparam int DEF_DEB_TICKS = 25000000;

  function automatic int ch_sel_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Operands are at most DUTY_W bits wide, so 32-bit math never overflows.
  function automatic int unsigned sat_add(input int unsigned v,
                                          input int unsigned step,
                                          input int unsigned lim);
    int unsigned s;
    s = v + step;
    return (s > lim) ? lim : s;
  endfunction

  function automatic int unsigned sat_sub(input int unsigned v,
                                          input int unsigned step);
    return (v >= step) ? (v - step) : 32'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : pwm_btn_debounce
// Description : Push-button conditioner: 2-FF synchroniser, slow sampling on
//               tick_en, and a one-clock press pulse on a rising edge of the
//               sampled level. A held button yields a single pulse.
// Ports       : clk         - system clock
//               rst_n       - asynchronous active-low reset
//               tick_en     - shared sample enable (one clk wide)
//               btn_raw     - raw asynchronous button, active-high
//               press_pulse - one-clock pulse per press
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_btn_debounce (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_en,
  input  logic btn_raw,
  output logic press_pulse
);

  logic sync1_q;
  logic sync2_q;
  logic samp_q;   // most recent slow sample
  logic prev_q;   // slow sample before that

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      samp_q  <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      if (tick_en) begin
        samp_q <= sync2_q;
        prev_q <= samp_q;
      end
    end
  end

  // Samples only move on tick_en, so gating with it keeps the pulse to the
  // single cycle in which prev_q catches up with samp_q.
  assign press_pulse = tick_en & samp_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/pwm_multi_ch.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi_ch
// Description : NUM_CH-channel PWM generator sharing one period counter.
//               Duties come from debounced inc/dec buttons or a direct write
//               on the ch_sel channel, land in a pending register, and move
//               to the active register at the end of each period.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               increase_duty   - raw button, +STEP on ch_sel
//               decrease_duty   - raw button, -STEP on ch_sel
//               ch_sel          - channel targeted by buttons / duty_wr
//               duty_wr         - strobe: load duty_wdata (saturated)
//               duty_wdata      - value to write
//               pwm_out         - registered PWM outputs
//               duty_rd         - active duty of ch_sel (0 if out of range)
//               period_start    - high during the cnt==0 cycle
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter  int NUM_CH    = 2,
  parameter  int PERIOD    = DEF_PERIOD,
  parameter  int DUTY_W    = DEF_DUTY_W,
  parameter  int STEP      = 1,
  parameter  int INIT_DUTY = 5,
  parameter  int DEB_TICKS = DEF_DEB_TICKS,
  localparam int CH_SEL_W  = ch_sel_w(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                increase_duty,
  input  logic                decrease_duty,
  input  logic [CH_SEL_W-1:0] ch_sel,
  input  logic                duty_wr,
  input  logic [DUTY_W-1:0]   duty_wdata,
  output logic [NUM_CH-1:0]   pwm_out,
  output logic [DUTY_W-1:0]   duty_rd,
  output logic                period_start
);

  localparam int TICK_W = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;

  // ---------------- shared debounce sample tick ----------------
  logic [TICK_W-1:0] tick_q;
  logic              tick_en_w;
  logic              inc_pulse_w;
  logic              dec_pulse_w;

  assign tick_en_w = (tick_q == TICK_W'(DEB_TICKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_q <= '0;
    else        tick_q <= tick_en_w ? '0 : tick_q + TICK_W'(1);
  end

  pwm_btn_debounce u_deb_inc (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_en    (tick_en_w),
    .btn_raw    (increase_duty),
    .press_pulse(inc_pulse_w)
  );

  pwm_btn_debounce u_deb_dec (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_en    (tick_en_w),
    .btn_raw    (decrease_duty),
    .press_pulse(dec_pulse_w)
  );

  // ---------------- period counter / duty registers ----------------
  // run_q holds cnt at 0 for the first edge after reset so the first period
  // is a full PERIOD cycles and period_start fires on that edge.
  logic              run_q;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic              last_w;
  logic [DUTY_W-1:0] pend_q [NUM_CH];
  logic [DUTY_W-1:0] pend_d [NUM_CH];
  logic [DUTY_W-1:0] act_q  [NUM_CH];
  logic [DUTY_W-1:0] act_d  [NUM_CH];
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic              ps_q;
  logic [DUTY_W-1:0] wr_sat_w;
  logic [DUTY_W-1:0] rd_w;

  assign wr_sat_w = (duty_wdata > DUTY_W'(PERIOD)) ? DUTY_W'(PERIOD) : duty_wdata;

  always_comb begin
    last_w = run_q && (cnt_q == DUTY_W'(PERIOD - 1));
    if (!run_q || last_w) cnt_d = '0;
    else                  cnt_d = cnt_q + DUTY_W'(1);

    for (int i = 0; i < NUM_CH; i++) begin
      // Transfer takes the pending value from before this edge's update.
      act_d[i]  = last_w ? pend_q[i] : act_q[i];
      pend_d[i] = pend_q[i];
      if (ch_sel == CH_SEL_W'(i)) begin
        if (duty_wr)
          pend_d[i] = wr_sat_w;
        else if (inc_pulse_w && dec_pulse_w)
          pend_d[i] = pend_q[i];
        else if (inc_pulse_w)
          pend_d[i] = DUTY_W'(sat_add(32'(pend_q[i]), 32'(STEP), 32'(PERIOD)));
        else if (dec_pulse_w)
          pend_d[i] = DUTY_W'(sat_sub(32'(pend_q[i]), 32'(STEP)));
      end
      // Compare against the post-edge counter/duty so the output register
      // shows the state of the cycle that follows the edge.
      pwm_d[i] = (cnt_d < act_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      pwm_q <= '0;
      ps_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        pend_q[i] <= DUTY_W'(INIT_DUTY);
        act_q[i]  <= DUTY_W'(INIT_DUTY);
      end
    end else begin
      run_q  <= 1'b1;
      cnt_q  <= cnt_d;
      pwm_q  <= pwm_d;
      ps_q   <= (cnt_d == '0);
      pend_q <= pend_d;
      act_q  <= act_d;
    end
  end

  // Out-of-range ch_sel matches no channel and reads back as 0.
  always_comb begin
    rd_w = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_SEL_W'(i)) rd_w = act_q[i];
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;
  assign duty_rd      = rd_w;

endmodule
`default_nettype wire

// File: doc/pwm_multi_ch.md
Name: pwm_multi_ch

Overview:
Parametrised multi-channel PWM generator. Successor to the single-channel button-driven PWM block.
- NUM_CH outputs share one period counter; each channel holds its own duty register.
- Duty is set from two debounced push-buttons (applied to the channel chosen by ch_sel) or by a direct register write.
- New duty values are double-buffered and take effect only at a period boundary, so output pulses are never glitched.
- Sits between board buttons / control logic and the motor-driver PWM pins (ja*).

Parameters:
NUM_CH, 2, number of PWM output channels (1..8)
PERIOD, 10, PWM period in clk cycles (>=2); duty range 0..PERIOD
DUTY_W, 4, duty/counter width; must satisfy 2**DUTY_W > PERIOD
STEP, 1, duty increment/decrement per debounced button press
INIT_DUTY, 5, reset duty for every channel (<=PERIOD)
DEB_TICKS, 25000000, clk cycles between debounce samples (use 2 in simulation)

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  asynchronous active-low reset
increase_duty  in  1  raw push-button, asynchronous, active-high
decrease_duty  in  1  raw push-button, asynchronous, active-high
ch_sel  in  max(1,$clog2(NUM_CH))  channel targeted by the buttons and by duty_wr
duty_wr  in  1  one-cycle strobe: load duty_wdata into the ch_sel channel
duty_wdata  in  DUTY_W  duty value to write; saturated to PERIOD
pwm_out  out  NUM_CH  PWM outputs, bit i = channel i
duty_rd  out  DUTY_W  active duty of the ch_sel channel (combinational mux)
period_start  out  1  one-cycle pulse when the period counter is 0

Behaviour:
Reset (rst_n=0, asynchronous):
- cnt=0; all active duty and pending duty registers = INIT_DUTY; debounce state cleared.
- pwm_out=0 while in reset; period_start=0.

Period counter:
- cnt counts 0..PERIOD-1, then wraps to 0.
- period_start = (cnt==0), asserted from the first clk edge after reset release.

Output:
- pwm_out[i] = registered (cnt_next < duty_active[i]). The output is registered, so there are no combinational glitches on pins.
- duty=0 gives a constant low output; duty=PERIOD gives a constant high output.

Debounce (per button):
- 2-FF synchroniser.
- Sample enable every DEB_TICKS cycles, taken from a free-running tick counter.
- Two sample FFs; press pulse = rising edge of the sampled level, qualified by the sample enable. One pulse per press, one clk wide.
- Held button: no auto-repeat.

Duty update, on the pending register of channel ch_sel. Priority:
1. duty_wr: pending = min(duty_wdata, PERIOD).
2. inc and dec pulses in the same cycle: no change.
3. inc pulse: pending = min(pending+STEP, PERIOD). Computed at DUTY_W+1 bits, so there is no wrap.
4. dec pulse: pending = (pending>=STEP) ? pending-STEP : 0.
- ch_sel is sampled in the same cycle as the strobe/pulse.
- A ch_sel change between press and pulse targets the new channel.
- Out-of-range ch_sel (>=NUM_CH) is ignored: no write, and duty_rd=0.

Shadow transfer:
- When cnt==PERIOD-1 (the last cycle of a period), duty_active[i] <= pending[i] for all i.
- Latency: a write becomes visible on pwm_out starting the first cycle of the next period.
- A write in the same cycle as the transfer is captured into pending and goes live one period later, unless written on that edge. Rule: the transfer uses the pending value before that edge's update.

duty_rd:
- Shows duty_active (not pending) for ch_sel.

Reset mid-period:
- Outputs drop immediately.
- After release, the period restarts at cnt=0 with INIT_DUTY.

Decomposition:
Package pwm_pkg holds:
- localparams for default PERIOD / DUTY_W / DEB_TICKS.
- A function sat_add/sat_sub on DUTY_W+1 bits.
- The CH_SEL_W = max(1,$clog2(NUM_CH)) helper.

Sub-module pwm_btn_debounce (clk, rst_n, tick_en, btn_raw -> press_pulse):
- Instantiated twice.
- The tick counter is shared in the top level.
- Expected RTL size: ~200 lines total.

Test Plan:
Setup for all scenarios: PERIOD=10, NUM_CH=2, DEB_TICKS=2, INIT_DUTY=5.

1. Reset release: each channel shows 5 high / 5 low per 10 clk. period_start pulses every 10 clk. pwm_out=0 while rst_n=0.
2. Press increase_duty 6 times on ch_sel=0: duty_rd steps 6..10, then holds at 10. Channel 0 becomes constant high; channel 1 is unchanged at 5/10.
3. Press decrease_duty 7 times on ch_sel=1: duty clamps at 0, pwm_out[1] constant low, no wrap to 15. Then hold the button 100 clk: exactly one further pulse is seen (no change at 0).
4. duty_wr=1, duty_wdata=3, ch_sel=0, at cnt=4:
   - current period keeps the old duty;
   - next period shows 3 high / 7 low;
   - duty_wdata=15 saturates to 10.
5. Drive both buttons together (debounced pulses coincide): duty unchanged. duty_wr together with an inc pulse: the write value wins.
6. Assert rst_n low at cnt=7 with duty=8: pwm_out drops asynchronously. After release, cnt restarts at 0 and duty is back to 5.
